// File: rtl/decode_imm_pipe_pkg.sv
// Opcode, CSR and immediate-format types shared by the decode-stage immediate pipe.
// Combinational helpers only; no timing or flow-control behaviour lives here.
// imm_extend produces the full 64-bit form; callers truncate to their XLEN.
package instructions_pkg;
    typedef enum logic [6:0] {
        OPC_LOAD     = 7'h03,
        OPC_MISC_MEM = 7'h0F,
        OPC_OP_IMM   = 7'h13,
        OPC_AUIPC    = 7'h17,
        OPC_STORE    = 7'h23,
        OPC_OP       = 7'h33,
        OPC_LUI      = 7'h37,
        OPC_BRANCH   = 7'h63,
        OPC_JALR     = 7'h67,
        OPC_JAL      = 7'h6F,
        OPC_SYSTEM   = 7'h73
    } opcode_t;

    typedef logic [2:0] funct3_t;
endpackage

package csr_pkg;
    typedef enum logic [2:0] {
        CSRRW  = 3'b001,
        CSRRS  = 3'b010,
        CSRRC  = 3'b011,
        CSRRWI = 3'b101,
        CSRRSI = 3'b110,
        CSRRCI = 3'b111
    } csr_funct3_t;

    // funct3 bit selecting the uimm (rs1-field) operand form
    localparam int CSR_SEL_IMM = 2;
endpackage

package imm_gen_pkg;
    localparam int XLEN_MAX    = 64;
    localparam int IMM_VALUE_W = XLEN_MAX;
    localparam int IMM_TYPE_W  = 3;

    typedef enum logic [IMM_TYPE_W-1:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_C    = 3'd6
    } imm_type_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_t;

    // Every format is a sign or zero extension, so the low XLEN bits of this
    // 64-bit result are exactly the XLEN=32 value as well.
    function automatic logic [IMM_VALUE_W-1:0] imm_extend(input logic [31:0] instr,
                                                          input imm_type_t imm_type);
        logic [IMM_VALUE_W-1:0] v;
        v = '0;
        case (imm_type)
            IMM_I: v = {{52{instr[31]}}, instr[31:20]};
            IMM_S: v = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: v = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U: v = {{32{instr[31]}}, instr[31:12], 12'b0};
            IMM_J: v = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_C: v = {59'b0, instr[19:15]};
            default: v = '0;
        endcase
        return v;
    endfunction
endpackage

// File: rtl/decode_imm_pipe_lane.sv
// Single-lane immediate format select and extension (DECODE_IMM_ILLEGAL_EN adds illegal flag).
// Purely combinational, zero latency; no flow control.
module decode_imm_lane
    import instructions_pkg::*;
    import csr_pkg::*;
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]           instr,
    input  logic                  lane_en,
    output logic [IMM_TYPE_W-1:0] imm_type,
    output logic [XLEN-1:0]       imm
`ifdef DECODE_IMM_ILLEGAL_EN
    ,
    output logic                  illegal
`endif
);

    imm_type_t sel_type;
    logic      known_op;

    always_comb begin
        sel_type = IMM_NONE;
        known_op = 1'b1;
        case (instr[6:0])
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: sel_type = IMM_I;
            OPC_STORE:                      sel_type = IMM_S;
            OPC_BRANCH:                     sel_type = IMM_B;
            OPC_LUI, OPC_AUIPC:             sel_type = IMM_U;
            OPC_JAL:                        sel_type = IMM_J;
            OPC_SYSTEM:                     sel_type = instr[12+CSR_SEL_IMM] ? IMM_C : IMM_NONE;
            OPC_OP, OPC_MISC_MEM:           sel_type = IMM_NONE;
            default:                        known_op = 1'b0;
        endcase
        if (!lane_en) begin
            sel_type = IMM_NONE;
        end
    end

    assign imm_type = sel_type;
    assign imm      = XLEN'(imm_extend(instr, sel_type));

`ifdef DECODE_IMM_ILLEGAL_EN
    assign illegal = lane_en & ((instr[1:0] != 2'b11) | ~known_op);
`endif

endmodule

// File: rtl/decode_imm_pipe.sv
// Registered NUM_LANES-wide immediate decoder; optional DECODE_IMM_ILLEGAL_EN adds out_illegal.
// Latency 1 cycle from accept to out_valid; two-entry skid buffer (main + skid).
// in_ready depends only on registered state; flush empties the buffer and blocks that cycle's accept.
module decode_imm_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NUM_LANES = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [32*NUM_LANES-1:0]         in_instr,
    input  logic [NUM_LANES-1:0]            in_lane_en,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_LANES-1:0]            out_lane_en,
    output logic [IMM_TYPE_W*NUM_LANES-1:0] out_imm_type,
    output logic [XLEN*NUM_LANES-1:0]       out_imm
`ifdef DECODE_IMM_ILLEGAL_EN
    ,
    output logic [NUM_LANES-1:0]            out_illegal
`endif
);

    localparam int TW = IMM_TYPE_W * NUM_LANES;
    localparam int VW = XLEN * NUM_LANES;
`ifdef DECODE_IMM_ILLEGAL_EN
    localparam int PW = 2 * NUM_LANES + TW + VW;
`else
    localparam int PW = NUM_LANES + TW + VW;
`endif

    logic [TW-1:0]        dec_type;
    logic [VW-1:0]        dec_imm;
    logic [PW-1:0]        dec_pay;
    logic [PW-1:0]        main_q, main_d;
    logic [PW-1:0]        skid_q, skid_d;
    skid_state_t          state_q, state_d;
    logic                 accept, pop;
`ifdef DECODE_IMM_ILLEGAL_EN
    logic [NUM_LANES-1:0] dec_ill;
`endif

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        decode_imm_lane #(.XLEN(XLEN)) u_lane (
            .instr    (in_instr[32*i +: 32]),
            .lane_en  (in_lane_en[i]),
            .imm_type (dec_type[IMM_TYPE_W*i +: IMM_TYPE_W]),
            .imm      (dec_imm[XLEN*i +: XLEN])
`ifdef DECODE_IMM_ILLEGAL_EN
            ,
            .illegal  (dec_ill[i])
`endif
        );
    end

    // One flat payload keeps the buffer moves identical for both builds.
`ifdef DECODE_IMM_ILLEGAL_EN
    assign dec_pay = {dec_ill, in_lane_en, dec_type, dec_imm};
    assign {out_illegal, out_lane_en, out_imm_type, out_imm} = main_q;
`else
    assign dec_pay = {in_lane_en, dec_type, dec_imm};
    assign {out_lane_en, out_imm_type, out_imm} = main_q;
`endif

    assign in_ready  = (state_q != SKID_TWO);
    assign out_valid = (state_q != SKID_EMPTY);
    assign accept    = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            SKID_EMPTY: begin
                if (accept) begin
                    state_d = SKID_ONE;
                    main_d  = dec_pay;
                end
            end
            SKID_ONE: begin
                if (accept && pop) begin
                    main_d = dec_pay;
                end else if (accept) begin
                    state_d = SKID_TWO;
                    skid_d  = dec_pay;
                end else if (pop) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_TWO: begin
                if (pop) begin
                    state_d = SKID_ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
        if (flush) begin
            state_d = SKID_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SKID_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_decode_imm_pipe.sv
// Scoreboard bench: a 32-bit two-lane and a 64-bit one-lane decoder share one stimulus stream,
// with expected beats queued on accept and compared whenever a beat is presented.
module tb_decode_imm_pipe;
    import imm_gen_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush, in_valid, out_ready;
    logic [63:0] in_instr;
    logic [1:0]  in_lane_en;

    logic        in_ready32, out_valid32;
    logic [1:0]  out_en32;
    logic [5:0]  out_type32;
    logic [63:0] out_imm32;
    logic        in_ready64, out_valid64;
    logic [0:0]  out_en64;
    logic [2:0]  out_type64;
    logic [63:0] out_imm64;
`ifdef DECODE_IMM_ILLEGAL_EN
    logic [1:0]  ill32;
    logic [0:0]  ill64;
`endif

    decode_imm_pipe #(.XLEN(32), .NUM_LANES(2)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_lane_en(in_lane_en), .out_valid(out_valid32),
        .out_ready(out_ready), .out_lane_en(out_en32), .out_imm_type(out_type32),
        .out_imm(out_imm32)
`ifdef DECODE_IMM_ILLEGAL_EN
        , .out_illegal(ill32)
`endif
    );

    decode_imm_pipe #(.XLEN(64), .NUM_LANES(1)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr[31:0]), .in_lane_en(in_lane_en[0:0]), .out_valid(out_valid64),
        .out_ready(out_ready), .out_lane_en(out_en64), .out_imm_type(out_type64),
        .out_imm(out_imm64)
`ifdef DECODE_IMM_ILLEGAL_EN
        , .out_illegal(ill64)
`endif
    );

    typedef struct {
        logic [1:0]  en;
        logic [2:0]  t0, t1;
        logic [63:0] v0_32, v1_32, v0_64;
        logic [1:0]  ill;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic imm_type_t ref_type(input logic [31:0] ins, input logic en);
        if (!en) return IMM_NONE;
        case (ins[6:0])
            7'h67, 7'h03, 7'h13: return IMM_I;
            7'h23:               return IMM_S;
            7'h63:               return IMM_B;
            7'h37, 7'h17:        return IMM_U;
            7'h6F:               return IMM_J;
            7'h73:               return ins[14] ? IMM_C : IMM_NONE;
            default:             return IMM_NONE;
        endcase
    endfunction

    // Immediate as a signed integer, then reduced to the lane width.
    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic en, input int xlen);
        longint      v;
        logic [63:0] r;
        v = 0;
        case (ref_type(ins, en))
            IMM_I: begin v = ins[31:20]; if (v >= 2048) v -= 4096; end
            IMM_S: begin v = {ins[31:25], ins[11:7]}; if (v >= 2048) v -= 4096; end
            IMM_B: begin v = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; if (v >= 4096) v -= 8192; end
            IMM_U: begin v = longint'(ins[31:12]) * 4096; if (v >= 64'sh80000000) v -= 64'sh100000000; end
            IMM_J: begin v = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; if (v >= 1048576) v -= 2097152; end
            IMM_C: v = ins[19:15];
            default: v = 0;
        endcase
        r = v;
        if (xlen == 32) r[63:32] = '0;
        return r;
    endfunction

    function automatic logic ref_ill(input logic [31:0] ins, input logic en);
        logic known;
        case (ins[6:0])
            7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h13, 7'h33, 7'h37, 7'h17, 7'h73, 7'h0F: known = 1'b1;
            default: known = 1'b0;
        endcase
        return en && ((ins[1:0] != 2'b11) || !known);
    endfunction

    function automatic exp_t mk(input logic [63:0] ins, input logic [1:0] en);
        exp_t e;
        e.en    = en;
        e.t0    = ref_type(ins[31:0], en[0]);
        e.t1    = ref_type(ins[63:32], en[1]);
        e.v0_32 = ref_imm(ins[31:0], en[0], 32);
        e.v1_32 = ref_imm(ins[63:32], en[1], 32);
        e.v0_64 = ref_imm(ins[31:0], en[0], 64);
        e.ill   = {ref_ill(ins[63:32], en[1]), ref_ill(ins[31:0], en[0])};
        return e;
    endfunction

    // Monitor: the model's occupancy is the number of beats owed downstream.
    int   sz;
    exp_t e;
    always @(negedge clk) begin
        if (mon_en) begin
            sz = q.size();
            check("in_ready32", 64'(in_ready32), 64'(sz < 2));
            check("in_ready64", 64'(in_ready64), 64'(sz < 2));
            check("out_valid32", 64'(out_valid32), 64'(sz > 0));
            check("out_valid64", 64'(out_valid64), 64'(sz > 0));
            if (sz > 0) begin
                e = q[0];
                check("lane_en32", 64'(out_en32), 64'(e.en));
                check("type32_l0", 64'(out_type32[2:0]), 64'(e.t0));
                check("type32_l1", 64'(out_type32[5:3]), 64'(e.t1));
                check("imm32_l0", 64'(out_imm32[31:0]), e.v0_32);
                check("imm32_l1", 64'(out_imm32[63:32]), e.v1_32);
                check("lane_en64", 64'(out_en64), 64'(e.en[0]));
                check("type64", 64'(out_type64), 64'(e.t0));
                check("imm64", out_imm64, e.v0_64);
`ifdef DECODE_IMM_ILLEGAL_EN
                check("illegal32", 64'(ill32), 64'(e.ill));
                check("illegal64", 64'(ill64), 64'(e.ill[0]));
`endif
            end
            if (!rst_n || flush) begin
                q.delete();
            end else begin
                if (sz > 0 && out_ready) void'(q.pop_front());
                if (in_valid && sz < 2) q.push_back(mk(in_instr, in_lane_en));
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] en);
        int n;
        bit done;
        n    = 0;
        done = 0;
        in_instr   = {b, a};
        in_lane_en = en;
        in_valid   = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready32 && !flush) begin
                done = 1;
            end else begin
                n++;
                if (n > 50) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", n);
                    done = 1;
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] ins;
        logic [6:0]  ops [14];
        ops = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37,
                7'h63, 7'h67, 7'h6F, 7'h73, 7'h00, 7'h7F, 7'h5B};
        ins = $urandom;
        if ($urandom_range(7) != 0) ins[6:0] = ops[$urandom_range(13)];
        return ins;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_lane_en = '0;
        repeat (2) @(posedge clk);
        #1 mon_en = 1;
        @(negedge clk);
        check("rst_imm32", out_imm32, 64'h0);
        check("rst_type32", 64'(out_type32), 64'(IMM_NONE));
        check("rst_en32", 64'(out_en32), 64'h0);
        check("rst_imm64", out_imm64, 64'h0);
        check("rst_type64", 64'(out_type64), 64'(IMM_NONE));
`ifdef DECODE_IMM_ILLEGAL_EN
        check("rst_ill32", 64'(ill32), 64'h0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed values: addi -1, beq -4, csrrwi uimm 5, lui 0x80000, jal 0
        send(32'hFFF00093, 32'h00000013, 2'b01);
        send(32'hFE000EE3, 32'h3002D073, 2'b11);
        send(32'h3002D073, 32'hFE000EE3, 2'b11);
        send(32'h80000037, 32'h0000006F, 2'b11);
        send(32'h0000006F, 32'h80000037, 2'b11);
        send(32'h00000000, 32'h00000013, 2'b11);
        send(32'h00000000, 32'h00000013, 2'b10);
        idle(3);

        // Backpressure: third beat held until downstream drains
        out_ready = 1'b0;
        send(32'h00500093, 32'h00A12023, 2'b11);
        send(32'h000010B7, 32'hFFF08067, 2'b11);
        fork
            send(32'h0080006F, 32'h00001063, 2'b11);
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle(4);

        // Flush with both entries full and a new beat offered
        out_ready = 1'b0;
        send(32'h12345037, 32'h00000013, 2'b11);
        send(32'h80000017, 32'h00000013, 2'b01);
        in_instr = {32'h00000013, 32'hFFF00093}; in_lane_en = 2'b11;
        in_valid = 1'b1; flush = 1'b1;
        idle(1);
        in_valid = 1'b0; flush = 1'b0;
        idle(2);
        out_ready = 1'b1;
        idle(2);

        // Randomized traffic with stalls, flushes and occasional reset
        repeat (3000) begin
            rst_n      = ($urandom_range(199) != 0);
            flush      = ($urandom_range(15) == 0);
            in_valid   = ($urandom_range(3) != 0);
            out_ready  = ($urandom_range(2) != 0);
            in_lane_en = 2'($urandom);
            in_instr   = {rnd_instr(), rnd_instr()};
            idle(1);
        end
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        idle(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
